// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the jump opcode, the instruction field positions and the fetch FSM states.
package fetch_queue_pkg;

  localparam logic [5:0] OP_J   = 6'd2;
  localparam int         OPC_HI = 31;
  localparam int         OPC_LO = 26;
  localparam int         IMM_HI = 25;
  localparam int         IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push, pop, flush and occupancy count.
// Depth is a power of two, so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, one-outstanding I-cache handshake,
// optional jump pre-decode and a FIFO of {pc, instr} feeding decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 32,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter bit              PREDECODE = 1'b1,
  localparam int             CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  output logic               icache_req,
  output logic [PC_W-1:0]    icache_addr,
  input  logic               icache_ack,
  input  logic [INSTR_W-1:0] icache_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   fill_level
);

  localparam int CNX_W = CNT_W + 1;

  fetch_state_e            state_q, state_d;
  logic [PC_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]         icache_addr_q, icache_addr_d;
  logic                    icache_req_q, icache_req_d;
  logic                    push, pop, flush;
  logic [CNX_W-1:0]        cnt_nx;
  logic                    room;
  logic                    is_jump;
  logic [PC_W-1:0]         jump_off;
  logic [PC_W-1:0]         next_pc;
  logic [PC_W+INSTR_W-1:0] head_data;

  if (PREDECODE) begin : g_predecode
    logic signed [IMM_HI-IMM_LO:0] imm;
    assign imm      = icache_data[IMM_HI:IMM_LO];
    assign is_jump  = (icache_data[OPC_HI:OPC_LO] == OP_J);
    assign jump_off = PC_W'(imm);
  end else begin : g_no_predecode
    assign is_jump  = 1'b0;
    assign jump_off = '0;
  end

  assign next_pc = is_jump ? (icache_addr_q + jump_off) : (icache_addr_q + PC_W'(1));

  // Redirect wins over everything: the flush discards any same-cycle push or pop.
  assign flush  = clk_en && redirect;
  assign push   = clk_en && !redirect && (state_q == BUSY) && icache_ack;
  assign pop    = clk_en && !redirect && out_valid && out_ready;
  assign cnt_nx = {1'b0, fill_level} + CNX_W'(push) - CNX_W'(pop);
  assign room   = (cnt_nx < CNX_W'(DEPTH));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    icache_addr_d = icache_addr_q;
    if (clk_en) begin
      if (redirect) begin
        fetch_pc_d = redirect_pc;
        state_d    = ((state_q != IDLE) && !icache_ack) ? DROP : IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (room) begin
              state_d       = BUSY;
              icache_addr_d = fetch_pc_q;
            end
          end
          BUSY: begin
            if (icache_ack) begin
              fetch_pc_d = next_pc;
              if (room) begin
                icache_addr_d = next_pc;
              end else begin
                state_d = IDLE;
              end
            end
          end
          DROP: begin
            if (icache_ack) begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    icache_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      icache_addr_q <= RESET_PC;
      icache_req_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      icache_addr_q <= icache_addr_d;
      icache_req_q  <= icache_req_d;
    end
  end

  sync_fifo #(
    .WIDTH(PC_W + INSTR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({icache_addr_q, icache_data}),
    .pop       (pop),
    .flush     (flush),
    .head_valid(out_valid),
    .head_data (head_data),
    .count     (fill_level)
  );

  assign icache_req  = icache_req_q;
  assign icache_addr = icache_addr_q;
  assign out_pc      = head_data[PC_W+INSTR_W-1:INSTR_W];
  assign out_instr   = head_data[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random traffic,
// all compared against a queue-based model of the fetch stream.
module tb_fetch_queue;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;

  logic               clk;
  logic               rst_n;
  logic               clk_en;
  logic               icache_req;
  logic [PC_W-1:0]    icache_addr;
  logic               icache_ack;
  logic [INSTR_W-1:0] icache_data;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CNT_W-1:0]   fill_level;

  fetch_queue #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000),
    .PREDECODE(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .icache_req (icache_req),
    .icache_addr(icache_addr),
    .icache_ack (icache_ack),
    .icache_data(icache_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  // Model of the fetch stream: what decode should see, and which request is in flight.
  entry_t          m_q[$];
  bit              m_out;
  bit              m_drop;
  logic [PC_W-1:0] m_addr;
  logic [PC_W-1:0] m_fpc;
  int              checks;
  int              failures;

  // Memory image: pseudo-random words, a few jumps, and a fixed backward jump at 0x10.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] w;
    if (a == 16'h0010) return {6'd2, 26'h3FFFFFC};
    w = {a, ~a} * 32'h9E3779B1;
    if (w[31:26] == 6'd2) w[31:26] = 6'd3;
    if (a[3:0] == 4'h9) w = {6'd2, {20{a[4]}}, w[5:0]};
    return w;
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] a, input logic [31:0] d);
    if (d[31:26] == 6'd2) return a + d[15:0];
    return a + 16'd1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_addr = 16'h0000;
    m_fpc  = 16'h0000;
  endtask

  task automatic model_update();
    bit pop_ok;
    bit was_drop;
    if (!clk_en) return;
    pop_ok = (m_q.size() > 0) && out_ready;
    if (redirect) begin
      m_q.delete();
      m_fpc = redirect_pc;
      if (m_out && !icache_ack) begin
        m_drop = 1'b1;
      end else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      return;
    end
    was_drop = 1'b0;
    if (pop_ok) void'(m_q.pop_front());
    if (m_out && icache_ack) begin
      if (m_drop) begin
        was_drop = 1'b1;
      end else begin
        m_q.push_back(entry_t'{pc: m_addr, instr: icache_data});
        m_fpc = model_next(m_addr, icache_data);
      end
      m_out  = 1'b0;
      m_drop = 1'b0;
    end
    if (!m_out && !was_drop && (m_q.size() < DEPTH)) begin
      m_out  = 1'b1;
      m_addr = m_fpc;
    end
  endtask

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit ack, input bit ready, input bit redir,
                               input logic [15:0] rpc, input bit use_d, input logic [31:0] d);
    clk_en      = en;
    icache_ack  = ack;
    out_ready   = ready;
    redirect    = redir;
    redirect_pc = rpc;
    icache_data = use_d ? d : mem_word(m_addr);
  endtask

  task automatic checkOutput();
    expect_eq("icache_req", 64'(icache_req), 64'(m_out));
    expect_eq("icache_addr", 64'(icache_addr), 64'(m_addr));
    expect_eq("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    expect_eq("fill_level", 64'(fill_level), 64'(m_q.size()));
    if (m_q.size() > 0) begin
      expect_eq("out_pc", 64'(out_pc), 64'(m_q[0].pc));
      expect_eq("out_instr", 64'(out_instr), 64'(m_q[0].instr));
    end
  endtask

  task automatic step(input bit en, input bit ack, input bit ready, input bit redir,
                      input logic [15:0] rpc, input bit use_d, input logic [31:0] d);
    applyStimulus(en, ack, ready, redir, rpc, use_d, d);
    @(posedge clk);
    model_update();
    #1;
    checkOutput();
  endtask

  task automatic check_reset_values(input string tag);
    expect_eq({tag, "_req"}, 64'(icache_req), 64'd0);
    expect_eq({tag, "_addr"}, 64'(icache_addr), 64'd0);
    expect_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    expect_eq({tag, "_fill"}, 64'(fill_level), 64'd0);
    expect_eq({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    expect_eq({tag, "_out_instr"}, 64'(out_instr), 64'd0);
  endtask

  // Redirect to a, drain any dropped request, then let the fetch at a issue.
  task automatic goto_pc(input logic [15:0] a);
    step(1, 0, 1, 1, a, 0, 0);
    for (int i = 0; i < 8 && m_out; i++) step(1, 1, 1, 0, 0, 0, 0);
    expect_eq("goto_idle", 64'(icache_req), 64'd0);
    step(1, 0, 1, 0, 0, 0, 0);
    expect_eq("goto_req", 64'(icache_req), 64'd1);
    expect_eq("goto_addr", 64'(icache_addr), 64'(a));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired before the end of the run");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // First enabled edge issues RESET_PC; then ack every cycle with decode always ready.
    step(1, 0, 1, 0, 0, 0, 0);
    expect_eq("first_req", 64'(icache_req), 64'd1);
    expect_eq("first_addr", 64'(icache_addr), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      expect_eq("stream_fill_le1", 64'(fill_level <= 3'd1), 64'd1);
    end

    // Back-pressure: the FIFO fills to DEPTH and requests stop.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0, 0);
    expect_eq("bp_fill_full", 64'(fill_level), 64'd4);
    expect_eq("bp_req_low", 64'(icache_req), 64'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0, 0);

    // Cache miss: request at 5 held for three cycles.
    goto_pc(16'h0005);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      expect_eq("miss_req", 64'(icache_req), 64'd1);
      expect_eq("miss_addr", 64'(icache_addr), 64'h5);
    end
    step(1, 1, 0, 0, 0, 0, 0);
    expect_eq("miss_valid", 64'(out_valid), 64'd1);
    expect_eq("miss_fill", 64'(fill_level), 64'd1);

    // Redirect while busy at 7: late ack is dropped, then 0x20 is fetched.
    goto_pc(16'h0007);
    step(1, 0, 1, 1, 16'h0020, 0, 0);
    expect_eq("drop_req", 64'(icache_req), 64'd1);
    expect_eq("drop_addr", 64'(icache_addr), 64'h7);
    step(1, 1, 1, 0, 0, 1, 32'hDEADBEEF);
    expect_eq("drop_fill", 64'(fill_level), 64'd0);
    expect_eq("drop_valid", 64'(out_valid), 64'd0);
    step(1, 0, 1, 0, 0, 0, 0);
    expect_eq("drop_next_addr", 64'(icache_addr), 64'h20);
    expect_eq("drop_next_req", 64'(icache_req), 64'd1);

    // Pre-decoded backward jump at 0x10 sends fetch to 0x0C.
    goto_pc(16'h0010);
    step(1, 1, 0, 0, 0, 0, 0);
    expect_eq("jump_addr", 64'(icache_addr), 64'h0C);
    expect_eq("jump_out_pc", 64'(out_pc), 64'h10);

    // Near-full FIFO, push+pop together, then redirect with ack and pop in one cycle.
    goto_pc(16'h0030);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    expect_eq("nf_fill", 64'(fill_level), 64'd3);
    expect_eq("nf_req", 64'(icache_req), 64'd1);
    step(1, 1, 1, 0, 0, 0, 0);
    expect_eq("pushpop_fill", 64'(fill_level), 64'd3);
    step(1, 1, 1, 1, 16'hFFFF, 0, 0);
    expect_eq("redir_ack_fill", 64'(fill_level), 64'd0);
    expect_eq("redir_ack_req", 64'(icache_req), 64'd0);
    step(1, 0, 1, 0, 0, 0, 0);
    expect_eq("wrap_req_addr", 64'(icache_addr), 64'hFFFF);
    step(1, 1, 0, 0, 0, 0, 0);
    expect_eq("wrap_next_addr", 64'(icache_addr), 64'h0000);
    expect_eq("wrap_out_pc", 64'(out_pc), 64'hFFFF);

    // Random traffic including clock-enable gaps and redirects near the wrap point.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                      : 16'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, rp, 0, 0);
    end

    // Asynchronous reset in the middle of traffic with an ack pending.
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
